// File: rtl/uart_tx_dev.sv
// Memory-mapped 8N1 serial transmitter: a 4-entry byte FIFO drained LSB-first onto txd.
// irq is a registered level that means "enabled, FIFO empty and transmitter idle".
module uart_tx_dev #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7f20,
    parameter logic [15:0] DIV       = 16'd16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        irq,
    output logic        txd
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_DIV    = 2'd3;
    localparam logic [15:0] DIV_MIN   = 16'd2;

    state_t      state_q, state_d;
    logic [7:0]  fifo_q [4];
    logic [7:0]  fifo_d [4];
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        ovr_q, ovr_d;
    logic        ien_q, ien_d;
    logic        txen_q, txen_d;
    logic [15:0] div_q, div_d;
    logic [15:0] period_q, period_d;
    logic [15:0] timer_q, timer_d;
    logic [2:0]  bitidx_q, bitidx_d;
    logic [7:0]  shift_q, shift_d;
    logic        irq_q, irq_d;

    logic        hit;
    logic        wr_en;
    logic        push;
    logic        push_ok;
    logic        pop;
    logic        empty;
    logic        full;
    logic        busy;
    logic        bit_done;
    logic        unused_bits;

    assign hit         = (addr[31:4] == BASE_ADDR[31:4]);
    assign wr_en       = we & hit;
    assign push        = wr_en && (addr[3:2] == REG_DATA);
    assign empty       = (cnt_q == 3'd0);
    assign full        = (cnt_q == 3'd4);
    // Overflow is judged on the count before any same-cycle pop.
    assign push_ok     = push && !full;
    assign pop         = (state_q == IDLE) && txen_q && !empty;
    assign bit_done    = (timer_q == period_q - 16'd1);
    assign irq         = irq_q;
    assign unused_bits = ^{wd[31:16], addr[1:0]};

    // ---------------------------------------------------------------- FSM: state register
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- FSM: next state
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pop) state_d = START;
            START:   if (bit_done) state_d = DATA;
            DATA:    if (bit_done && (bitidx_q == 3'd7)) state_d = STOP;
            STOP:    if (bit_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------------------------------------------------------- FSM: outputs
    always_comb begin
        txd  = 1'b1;
        busy = 1'b1;
        case (state_q)
            IDLE:    busy = 1'b0;
            START:   txd  = 1'b0;
            DATA:    txd  = shift_q[0];
            STOP:    txd  = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    // ---------------------------------------------------------------- FIFO and registers
    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovr_d    = ovr_q;
        ien_d    = ien_q;
        txen_d   = txen_q;
        div_d    = div_q;

        if (push_ok) begin
            fifo_d[wr_ptr_q] = wd[7:0];
            wr_ptr_d         = wr_ptr_q + 2'd1;
        end
        if (push && !push_ok) begin
            ovr_d = 1'b1;
        end
        if (wr_en && (addr[3:2] == REG_STATUS)) begin
            ovr_d = 1'b0;
        end
        if (wr_en && (addr[3:2] == REG_CTRL)) begin
            ien_d  = wd[0];
            txen_d = wd[1];
        end
        if (wr_en && (addr[3:2] == REG_DIV)) begin
            div_d = (wd[15:0] < DIV_MIN) ? DIV_MIN : wd[15:0];
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end

        cnt_d = cnt_q + {2'b00, push_ok} - {2'b00, pop};
    end

    // ---------------------------------------------------------------- bit timer and shifter
    always_comb begin
        period_d = period_q;
        timer_d  = timer_q;
        bitidx_d = bitidx_q;
        shift_d  = shift_q;

        if (state_q == IDLE) begin
            timer_d = 16'd0;
            if (pop) begin
                // The divisor is captured here so a DIV write mid-frame only affects the next frame.
                period_d = div_q;
                shift_d  = fifo_q[rd_ptr_q];
                bitidx_d = 3'd0;
            end
        end else if (bit_done) begin
            timer_d = 16'd0;
            if (state_q == DATA) begin
                shift_d  = {1'b0, shift_q[7:1]};
                bitidx_d = bitidx_q + 3'd1;
            end
        end else begin
            timer_d = timer_q + 16'd1;
        end

        irq_d = ien_q & empty & (state_q == IDLE);
    end

    // ---------------------------------------------------------------- control flops
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            cnt_q    <= 3'd0;
            ovr_q    <= 1'b0;
            ien_q    <= 1'b0;
            txen_q   <= 1'b0;
            div_q    <= DIV;
            period_q <= 16'd0;
            timer_q  <= 16'd0;
            bitidx_q <= 3'd0;
            shift_q  <= 8'd0;
            irq_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovr_q    <= ovr_d;
            ien_q    <= ien_d;
            txen_q   <= txen_d;
            div_q    <= div_d;
            period_q <= period_d;
            timer_q  <= timer_d;
            bitidx_q <= bitidx_d;
            shift_q  <= shift_d;
            irq_q    <= irq_d;
        end
    end

    // NOTE: the FIFO storage is not reset; pointers and count alone decide which entries are valid.
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

    // ---------------------------------------------------------------- read mux
    always_comb begin
        rd = 32'd0;
        if (hit) begin
            case (addr[3:2])
                REG_STATUS: rd = {26'd0, cnt_q, ovr_q, empty, busy};
                REG_CTRL:   rd = {30'd0, txen_q, ien_q};
                REG_DIV:    rd = {16'd0, div_q};
                default:    rd = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_dev.sv
// Directed bench for uart_tx_dev: register access, 8N1 framing, overrun, interrupt, clamp/miss, reset mid-frame.
module tb_uart_tx_dev;

    localparam logic [31:0] A_DATA   = 32'h0000_7f20;
    localparam logic [31:0] A_STATUS = 32'h0000_7f24;
    localparam logic [31:0] A_CTRL   = 32'h0000_7f28;
    localparam logic [31:0] A_DIV    = 32'h0000_7f2c;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        irq;
    logic        txd;

    int checks   = 0;
    int failures = 0;

    uart_tx_dev #(
        .BASE_ADDR(32'h0000_7f20),
        .DIV      (16'd16)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .addr (addr),
        .we   (we),
        .wd   (wd),
        .rd   (rd),
        .irq  (irq),
        .txd  (txd)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at a sample point (just after a rising edge); returns at the next sample point.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr = a;
        wd   = d;
        we   = 1'b1;
        @(posedge clk);
        #1;
        we   = 1'b0;
        wd   = 32'd0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        we   = 1'b0;
        #1;
        d = rd;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Waits (bounded) for a start bit, then checks txd, busy and irq=0 over the 10*p frame clocks.
    task automatic expect_frame(input logic [7:0] b, input int p, input string tag, output int waited);
        logic       exp_txd;
        logic [2:0] bi;
        addr = A_STATUS;
        we   = 1'b0;
        #1;
        waited = 0;
        while (txd !== 1'b0 && waited < 400) begin
            @(posedge clk);
            #1;
            waited++;
        end
        checks++;
        if (txd !== 1'b0) begin
            failures++;
            $display("FAIL %s_start: txd=%b, required 0 within 400 clocks", tag, txd);
            return;
        end
        for (int k = 0; k < 10 * p; k++) begin
            if (k < p) begin
                exp_txd = 1'b0;
            end else if (k < 9 * p) begin
                bi      = 3'((k - p) / p);
                exp_txd = b[bi];
            end else begin
                exp_txd = 1'b1;
            end
            checks++;
            if (txd !== exp_txd || rd[0] !== 1'b1 || irq !== 1'b0) begin
                failures++;
                $display("FAIL %s_clk%0d: txd=%b busy=%b irq=%b, required txd=%b busy=1 irq=0",
                         tag, k, txd, rd[0], irq, exp_txd);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset = 1'b1;
        we    = 1'b0;
        addr  = 32'd0;
        wd    = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        step(1);
        bus_read(A_STATUS, d);
        checks++;
        if (d !== 32'h2) begin failures++; $display("FAIL reset_status: got %h, required 00000002", d); end
        bus_read(A_CTRL, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL reset_ctrl: got %h, required 00000000", d); end
        bus_read(A_DIV, d);
        checks++;
        if (d !== 32'h10) begin failures++; $display("FAIL reset_div: got %h, required 00000010", d); end
        bus_read(A_DATA, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL reset_data_read: got %h, required 00000000", d); end
        checks++;
        if (txd !== 1'b1 || irq !== 1'b0) begin
            failures++;
            $display("FAIL reset_lines: txd=%b irq=%b, required txd=1 irq=0", txd, irq);
        end
    endtask

    task automatic test_single_byte();
        logic [31:0] d;
        int          w;
        bus_write(A_DIV, 32'd4);
        bus_write(A_CTRL, 32'h2);
        bus_write(A_DATA, 32'h55);
        expect_frame(8'h55, 4, "single", w);
        checks++;
        if (w != 1) begin failures++; $display("FAIL single_latency: waited %0d clk, required 1", w); end
        bus_read(A_STATUS, d);
        checks++;
        if (d !== 32'h2) begin failures++; $display("FAIL single_done_status: got %h, required 00000002", d); end
    endtask

    task automatic test_overrun();
        logic [31:0] d;
        int          w;
        logic [7:0]  bytes [4];
        bool_hi: begin end
        bytes[0] = 8'h11;
        bytes[1] = 8'h22;
        bytes[2] = 8'h33;
        bytes[3] = 8'h44;
        bus_write(A_CTRL, 32'h0);
        bus_write(A_DATA, 32'h11);
        bus_write(A_DATA, 32'h22);
        bus_write(A_DATA, 32'h33);
        bus_write(A_DATA, 32'h44);
        bus_write(A_DATA, 32'h55);
        bus_read(A_STATUS, d);
        checks++;
        if (d !== 32'h24) begin failures++; $display("FAIL ovr_full_status: got %h, required 00000024", d); end
        bus_write(A_CTRL, 32'h2);
        for (int i = 0; i < 4; i++) begin
            expect_frame(bytes[i], 4, "ovr_frame", w);
            checks++;
            if (w != 1) begin failures++; $display("FAIL ovr_gap%0d: waited %0d clk, required 1", i, w); end
        end
        bus_read(A_STATUS, d);
        checks++;
        if (d !== 32'h6) begin failures++; $display("FAIL ovr_drained_status: got %h, required 00000006", d); end
        begin
            int lows;
            lows = 0;
            for (int k = 0; k < 50; k++) begin
                if (txd !== 1'b1) lows++;
                step(1);
            end
            checks++;
            if (lows != 0) begin failures++; $display("FAIL ovr_fifth_byte: %0d low clocks, required 0", lows); end
        end
        bus_write(A_STATUS, 32'h0);
        bus_read(A_STATUS, d);
        checks++;
        if (d !== 32'h2) begin failures++; $display("FAIL ovr_clear: got %h, required 00000002", d); end
    endtask

    task automatic test_interrupt();
        int w;
        bus_write(A_CTRL, 32'h0);
        bus_write(A_DATA, 32'hC3);
        bus_write(A_DATA, 32'h3C);
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL irq_queued: got %b, required 0", irq); end
        bus_write(A_CTRL, 32'h3);
        expect_frame(8'hC3, 4, "irq_frame0", w);
        checks++;
        if (w != 1) begin failures++; $display("FAIL irq_frame0_latency: waited %0d, required 1", w); end
        expect_frame(8'h3C, 4, "irq_frame1", w);
        checks++;
        if (w != 1) begin failures++; $display("FAIL irq_frame1_gap: waited %0d, required 1", w); end
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL irq_stop_end: got %b, required 0", irq); end
        step(1);
        checks++;
        if (irq !== 1'b1) begin failures++; $display("FAIL irq_raise: got %b, required 1", irq); end
        bus_write(A_DATA, 32'h5A);
        step(1);
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL irq_push_drop: got %b, required 0", irq); end
        expect_frame(8'h5A, 4, "irq_frame2", w);
        step(2);
        checks++;
        if (irq !== 1'b1) begin failures++; $display("FAIL irq_reraise: got %b, required 1", irq); end
        bus_write(A_CTRL, 32'h2);
        step(1);
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL irq_ien_clear: got %b, required 0", irq); end
    endtask

    task automatic test_clamp_miss();
        logic [31:0] d;
        int          w;
        bus_write(A_DIV, 32'd1);
        bus_read(A_DIV, d);
        checks++;
        if (d !== 32'h2) begin failures++; $display("FAIL clamp_div1: got %h, required 00000002", d); end
        bus_write(A_DIV, 32'hABCD_0003);
        bus_read(A_DIV, d);
        checks++;
        if (d !== 32'h3) begin failures++; $display("FAIL div_upper_bits: got %h, required 00000003", d); end
        bus_write(A_DIV, 32'd0);
        bus_write(A_CTRL, 32'hFFFF_FFFE);
        bus_read(A_CTRL, d);
        checks++;
        if (d !== 32'h2) begin failures++; $display("FAIL ctrl_upper_bits: got %h, required 00000002", d); end
        bus_write(32'h0000_7f14, 32'hFFFF_FFFF);
        bus_write(32'h0000_7f10, 32'h0000_0077);
        bus_write(32'h0000_7f1c, 32'h0000_0009);
        bus_read(32'h0000_7f14, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL miss_read: got %h, required 00000000", d); end
        bus_read(A_STATUS, d);
        checks++;
        if (d !== 32'h2) begin failures++; $display("FAIL miss_status: got %h, required 00000002", d); end
        bus_read(A_DIV, d);
        checks++;
        if (d !== 32'h2) begin failures++; $display("FAIL miss_div: got %h, required 00000002", d); end
        bus_read(A_CTRL, d);
        checks++;
        if (d !== 32'h2) begin failures++; $display("FAIL miss_ctrl: got %h, required 00000002", d); end
        bus_write(A_DATA, 32'hA3);
        expect_frame(8'hA3, 2, "clamp_frame", w);
        checks++;
        if (w != 1) begin failures++; $display("FAIL clamp_latency: waited %0d, required 1", w); end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] d;
        bus_write(A_DIV, 32'd4);
        bus_write(A_DATA, 32'hF0);
        bus_write(A_DATA, 32'h0F);
        checks++;
        if (txd !== 1'b0) begin failures++; $display("FAIL rst_mid_start: txd=%b, required 0", txd); end
        step(17);
        bus_read(A_STATUS, d);
        checks++;
        if (txd !== 1'b0 || d !== 32'h9) begin
            failures++;
            $display("FAIL rst_mid_bit3: txd=%b status=%h, required txd=0 status=00000009", txd, d);
        end
        reset = 1'b1;
        step(1);
        bus_read(A_STATUS, d);
        checks++;
        if (txd !== 1'b1 || d !== 32'h2) begin
            failures++;
            $display("FAIL rst_mid_after: txd=%b status=%h, required txd=1 status=00000002", txd, d);
        end
        reset = 1'b0;
        step(1);
        bus_read(A_DIV, d);
        checks++;
        if (d !== 32'h10) begin failures++; $display("FAIL rst_mid_div: got %h, required 00000010", d); end
        begin
            int bad;
            bad = 0;
            for (int k = 0; k < 60; k++) begin
                if (txd !== 1'b1 || irq !== 1'b0) bad++;
                step(1);
            end
            checks++;
            if (bad != 0) begin failures++; $display("FAIL rst_mid_quiet: %0d bad clocks, required 0", bad); end
        end
    endtask

    initial begin
        reset = 1'b1;
        addr  = 32'd0;
        we    = 1'b0;
        wd    = 32'd0;
        test_reset();
        test_single_byte();
        test_overrun();
        test_interrupt();
        test_clamp_miss();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
